lsu_align: RTL and testbench

//  Load/store alignment unit in the MEM stage, between the EX/MEM register and the

---
 rtl/lsu_align_if.sv | 41 ++++
 rtl/lsu_align.sv | 202 ++++++++++++++++++++
 tb/tb_lsu_align.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_align_if.sv
// lsu_align_if: groups the pipeline request, the memory port and the response of the MEM-stage
// load/store alignment unit.
//   slave  : the alignment unit. It receives the request and mem_rdata, and it drives the
//            memory strobes and the response.
//   master : the pipeline and memory side. It drives the request and mem_rdata, and it
//            receives the strobes and the response.
// Signals:
//   req, mem_read, mem_write, func3, addr, wdata : request from the EX/MEM register
//   mem_idx, mem_re, mem_we, mem_be, mem_wdata   : word-organised data memory port
//   mem_rdata                                    : combinational read word from memory
//   load_data, done, stall, fault                : response to the pipeline
interface lsu_align_if #(
   parameter int unsigned IDX_W = 6
);
   logic             req;
   logic             mem_read;
   logic             mem_write;
   logic [2:0]       func3;
   logic [31:0]      addr;
   logic [31:0]      wdata;
   logic [IDX_W-1:0] mem_idx;
   logic             mem_re;
   logic             mem_we;
   logic [3:0]       mem_be;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;
   logic [31:0]      load_data;
   logic             done;
   logic             stall;
   logic             fault;

   modport slave (
      input  req, mem_read, mem_write, func3, addr, wdata, mem_rdata,
      output mem_idx, mem_re, mem_we, mem_be, mem_wdata, load_data, done, stall, fault
   );

   modport master (
      output req, mem_read, mem_write, func3, addr, wdata, mem_rdata,
      input  mem_idx, mem_re, mem_we, mem_be, mem_wdata, load_data, done, stall, fault
   );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: MEM-stage load/store alignment unit.
// It maps byte addresses and func3 onto a word-organised data memory. It produces the word
// index, the byte enables and the lane-shifted store data, and it sign- or zero-extends load
// results.
// An access that crosses a word boundary is split into two word accesses on consecutive
// cycles. The unit holds stall high during the first of those cycles.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset. While it is high, every output is held at zero.
//   bus : lsu_align_if.slave. It carries the request, the memory port and the response
//         (done / stall / fault / load_data).
// Parameters:
//   DEPTH : number of 32-bit words in the data memory. Word indices >= DEPTH fault.
//   IDX_W : width of mem_idx. Must satisfy 2**IDX_W >= DEPTH.
module lsu_align #(
   parameter int unsigned DEPTH = 40,
   parameter int unsigned IDX_W = 6
) (
   input logic        clk,
   input logic        rst,
   lsu_align_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StSecond} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;          // word index of the upper half
   logic [1:0]       off_q, off_d;
   logic [2:0]       func3_q, func3_d;
   logic             store_q, store_d;
   logic [31:0]      low_q, low_d;          // lower load bytes, already right-justified
   logic [31:0]      hi_wdata_q, hi_wdata_d;
   logic [3:0]       hi_be_q, hi_be_d;

   logic [1:0]  off;
   logic [31:0] idx_ext;
   logic [31:0] idx_plus1;
   logic        op_load;
   logic        op_store;
   logic        active;
   logic        both;
   logic        f3_legal;
   logic        split;
   logic        req_fault;
   logic [3:0]  mask;
   logic [4:0]  sh_lo;
   logic [7:0]  be_wide;
   logic [63:0] wd_wide;
   logic [31:0] rd_low;
   logic [5:0]  sh_hi;
   logic [31:0] rd_joined;

   // Request decode
   assign off       = bus.addr[1:0];
   assign idx_ext   = {2'b00, bus.addr[31:2]};
   assign idx_plus1 = idx_ext + 32'd1;
   assign op_load   = bus.req & bus.mem_read;
   assign op_store  = bus.req & bus.mem_write;
   assign active    = op_load | op_store;
   assign both      = bus.mem_read & bus.mem_write;

   always_comb begin
      f3_legal = 1'b0;
      case (bus.func3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = ~bus.mem_write;
         default:                f3_legal = 1'b0;
      endcase
   end

   always_comb begin
      mask = 4'b1111;
      case (bus.func3[1:0])
         2'b00:   mask = 4'b0001;
         2'b01:   mask = 4'b0011;
         default: mask = 4'b1111;
      endcase
   end

   assign split = ((bus.func3[1:0] == 2'b01) && (off == 2'b11)) ||
                  ((bus.func3[1:0] == 2'b10) && (off != 2'b00));

   assign req_fault = active && (both || !f3_legal || (idx_ext >= DEPTH) ||
                                 (split && (idx_plus1 >= DEPTH)));

   // Shifting into a double-width vector yields both halves of a split access at once:
   // the low half goes to word idx and the high half goes to word idx+1.
   assign sh_lo   = {off, 3'b000};
   assign be_wide = {4'b0000, mask} << off;
   assign wd_wide = {32'h0, bus.wdata} << sh_lo;
   assign rd_low  = bus.mem_rdata >> sh_lo;

   // Upper word's low bytes land just above the off_q-byte gap left by the first word.
   assign sh_hi     = 6'd32 - {1'b0, off_q, 3'b000};
   assign rd_joined = (bus.mem_rdata << sh_hi) | low_q;

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
      logic [31:0] r;
      case (f3)
         3'b000:  r = {{24{v[7]}}, v[7:0]};
         3'b001:  r = {{16{v[15]}}, v[15:0]};
         3'b100:  r = {24'h0, v[7:0]};
         3'b101:  r = {16'h0, v[15:0]};
         default: r = v;
      endcase
      return r;
   endfunction

   // Next state and outputs
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      off_d         = off_q;
      func3_d       = func3_q;
      store_d       = store_q;
      low_d         = low_q;
      hi_wdata_d    = hi_wdata_q;
      hi_be_d       = hi_be_q;
      bus.mem_idx   = '0;
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = 4'b0000;
      bus.mem_wdata = 32'h0;
      bus.load_data = 32'h0;
      bus.done      = 1'b0;
      bus.stall     = 1'b0;
      bus.fault     = 1'b0;

      if (!rst) begin
         unique case (state_q)
            StIdle: begin
               if (active) begin
                  if (req_fault) begin
                     // Nothing reaches memory, so a faulting split store leaves no half.
                     bus.fault = 1'b1;
                     bus.done  = 1'b1;
                  end else begin
                     bus.mem_idx   = idx_ext[IDX_W-1:0];
                     bus.mem_be    = be_wide[3:0];
                     bus.mem_wdata = wd_wide[31:0];
                     bus.mem_re    = op_load;
                     bus.mem_we    = op_store;
                     if (split) begin
                        bus.stall  = 1'b1;
                        state_d    = StSecond;
                        idx_d      = idx_plus1[IDX_W-1:0];
                        off_d      = off;
                        func3_d    = bus.func3;
                        store_d    = op_store;
                        low_d      = rd_low;
                        hi_wdata_d = wd_wide[63:32];
                        hi_be_d    = be_wide[7:4];
                     end else begin
                        bus.done = 1'b1;
                        if (op_load) begin
                           bus.load_data = extend(bus.func3, rd_low);
                        end
                     end
                  end
               end
            end
            StSecond: begin
               // Upper half runs purely from latched values; request inputs are ignored.
               bus.mem_idx   = idx_q;
               bus.mem_be    = hi_be_q;
               bus.mem_wdata = hi_wdata_q;
               bus.mem_re    = ~store_q;
               bus.mem_we    = store_q;
               bus.done      = 1'b1;
               if (!store_q) begin
                  bus.load_data = extend(func3_q, rd_joined);
               end
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         off_q      <= 2'b00;
         func3_q    <= 3'b000;
         store_q    <= 1'b0;
         low_q      <= 32'h0;
         hi_wdata_q <= 32'h0;
         hi_be_q    <= 4'b0000;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         off_q      <= off_d;
         func3_q    <= func3_d;
         store_q    <= store_d;
         low_q      <= low_d;
         hi_wdata_q <= hi_wdata_d;
         hi_be_q    <= hi_be_d;
      end
   end

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: bench for lsu_align.
// A word memory attached to the DUT port is checked against a byte-addressed reference
// memory. Expected load values, byte lanes, split/fault classification and timing all come
// from byte-level arithmetic on the reference memory.
module tb_lsu_align;
   localparam int unsigned DEPTH = 40;
   localparam int unsigned IDX_W = 6;
   localparam int unsigned LIM   = 4 * DEPTH;

   logic clk = 1'b0;
   logic rst;
   logic preset;

   always #5 clk = ~clk;

   lsu_align_if #(.IDX_W(IDX_W)) bus ();

   lsu_align #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [7:0]  refb [LIM];
   logic [31:0] mem  [DEPTH];
   int          total = 0;
   int          bad   = 0;

   function automatic logic [31:0] ref_word(input int w);
      return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
   endfunction

   always_comb begin
      bus.mem_rdata = 32'h0;
      if (int'(bus.mem_idx) < DEPTH) bus.mem_rdata = mem[bus.mem_idx];
   end

   always @(posedge clk) begin
      if (preset) begin
         for (int w = 0; w < DEPTH; w++) mem[w] <= ref_word(w);
      end else if (bus.mem_we && int'(bus.mem_idx) < DEPTH) begin
         for (int i = 0; i < 4; i++)
            if (bus.mem_be[i]) mem[bus.mem_idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // {done, stall, fault, mem_we, mem_re}
   function automatic logic [31:0] ctl();
      return {27'h0, bus.done, bus.stall, bus.fault, bus.mem_we, bus.mem_re};
   endfunction

   task automatic idle_inputs();
      bus.req       = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.func3     = 3'b000;
      bus.addr      = 32'h0;
      bus.wdata     = 32'h0;
   endtask

   function automatic int size_of(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      int n;
      n = size_of(f3);
      v = 32'h0;
      for (int k = 0; k < n; k++) v = v | (32'(refb[int'(a) + k]) << (8 * k));
      if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic preset_mem();
      preset = 1'b1;
      @(posedge clk);
      #1 preset = 1'b0;
   endtask

   task automatic setup_directed();
      for (int i = 0; i < int'(LIM); i++) refb[i] = 8'h00;
      refb[4] = 8'h11; refb[5] = 8'h22; refb[6] = 8'h33; refb[7]  = 8'h44;
      refb[8] = 8'hAA; refb[9] = 8'hBB; refb[10] = 8'hCC; refb[11] = 8'hDD;
      preset_mem();
   endtask

   task automatic chk_mem(input string tag);
      for (int w = 0; w < int'(DEPTH); w++) chk($sformatf("%s[%0d]", tag, w), mem[w], ref_word(w));
   endtask

   task automatic run_op(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, output logic [31:0] ld);
      int          n;
      bit          legal;
      bit          efault;
      bit          emis;
      logic [32:0] last;
      logic [32:0] b;
      logic [3:0]  be1;
      logic [3:0]  be2;
      n     = size_of(f3);
      legal = (rd && wr) ? 1'b0 : wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      last  = {1'b0, a} + 33'(n) - 33'd1;
      efault = (rd || wr) && (!legal || last >= 33'(LIM));
      emis   = ({1'b0, a} >> 2) != (last >> 2);
      be1 = 4'b0000;
      be2 = 4'b0000;
      for (int k = 0; k < n; k++) begin
         b = {1'b0, a} + 33'(k);
         if ((b >> 2) == ({1'b0, a} >> 2)) be1[b[1:0]] = 1'b1;
         else be2[b[1:0]] = 1'b1;
      end

      @(posedge clk);
      #1;
      bus.req       = 1'b1;
      bus.mem_read  = rd;
      bus.mem_write = wr;
      bus.func3     = f3;
      bus.addr      = a;
      bus.wdata     = wd;
      @(negedge clk);
      if (!rd && !wr) begin
         chk({tag, "_noop_ctl"}, ctl(), 32'h0);
      end else if (efault) begin
         chk({tag, "_flt_ctl"}, ctl(), {27'h0, 5'b10100});
         chk({tag, "_flt_be"}, 32'(bus.mem_be), 32'h0);
         chk({tag, "_flt_ld"}, bus.load_data, 32'h0);
      end else if (!emis) begin
         chk({tag, "_ctl"}, ctl(), {27'h0, 1'b1, 1'b0, 1'b0, wr, rd});
         chk({tag, "_idx"}, 32'(bus.mem_idx), a >> 2);
         chk({tag, "_be"}, 32'(bus.mem_be), 32'(be1));
         if (rd) chk({tag, "_ld"}, bus.load_data, ref_load(f3, a));
      end else begin
         chk({tag, "_c1_ctl"}, ctl(), {27'h0, 1'b0, 1'b1, 1'b0, wr, rd});
         chk({tag, "_c1_idx"}, 32'(bus.mem_idx), a >> 2);
         chk({tag, "_c1_be"}, 32'(bus.mem_be), 32'(be1));
         @(posedge clk);
         #1;
         // The second half must not depend on whatever the pipe presents now.
         bus.req       = 1'($urandom);
         bus.mem_read  = 1'($urandom);
         bus.mem_write = 1'($urandom);
         bus.func3     = 3'($urandom);
         bus.addr      = $urandom;
         bus.wdata     = $urandom;
         @(negedge clk);
         chk({tag, "_c2_ctl"}, ctl(), {27'h0, 1'b1, 1'b0, 1'b0, wr, rd});
         chk({tag, "_c2_idx"}, 32'(bus.mem_idx), (a >> 2) + 32'd1);
         chk({tag, "_c2_be"}, 32'(bus.mem_be), 32'(be2));
         if (rd) chk({tag, "_c2_ld"}, bus.load_data, ref_load(f3, a));
      end
      ld = bus.load_data;
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      chk({tag, "_after"}, ctl(), 32'h0);
      if (wr && !rd && !efault)
         for (int k = 0; k < n; k++) refb[int'(a) + k] = wd[8*k +: 8];
   endtask

   logic [31:0] ld;
   logic [2:0]  f3;
   logic [31:0] a;
   int          r;
   bit          rd;
   bit          wr;

   initial begin
      rst    = 1'b1;
      preset = 1'b0;
      idle_inputs();
      for (int i = 0; i < int'(LIM); i++) refb[i] = 8'h00;

      // Outputs are forced low in reset even with a valid request presented.
      bus.req      = 1'b1;
      bus.mem_read = 1'b1;
      bus.func3    = 3'b010;
      bus.addr     = 32'h4;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ctl", ctl(), 32'h0);
      chk("rst_be", 32'(bus.mem_be), 32'h0);
      chk("rst_ld", bus.load_data, 32'h0);
      chk("rst_idx", 32'(bus.mem_idx), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle_inputs();

      setup_directed();
      run_op("lw4", 1'b1, 1'b0, 3'b010, 32'h4, 32'h0, ld);
      chk("lw4_val", ld, 32'h4433_2211);
      setup_directed();
      run_op("lbB", 1'b1, 1'b0, 3'b000, 32'hB, 32'h0, ld);
      chk("lbB_val", ld, 32'hFFFF_FFDD);
      setup_directed();
      run_op("lbuB", 1'b1, 1'b0, 3'b100, 32'hB, 32'h0, ld);
      chk("lbuB_val", ld, 32'h0000_00DD);
      setup_directed();
      run_op("lhu6", 1'b1, 1'b0, 3'b101, 32'h6, 32'h0, ld);
      chk("lhu6_val", ld, 32'h0000_4433);
      setup_directed();
      run_op("lw6", 1'b1, 1'b0, 3'b010, 32'h6, 32'h0, ld);
      chk("lw6_val", ld, 32'hBBAA_4433);
      setup_directed();
      run_op("sh7", 1'b0, 1'b1, 3'b001, 32'h7, 32'h0000_BEEF, ld);
      chk("sh7_m1", mem[1], 32'hEF33_2211);
      chk("sh7_m2", mem[2], 32'hDDCC_BBBE);
      setup_directed();
      run_op("lw_oor", 1'b1, 1'b0, 3'b010, LIM, 32'h0, ld);
      run_op("sw_oor", 1'b0, 1'b1, 3'b010, LIM - 2, 32'h1234_5678, ld);
      run_op("rdwr", 1'b1, 1'b1, 3'b010, 32'h4, 32'h1234_5678, ld);
      run_op("lw_bad", 1'b1, 1'b0, 3'b011, 32'h4, 32'h0, ld);
      chk_mem("flt_mem");

      // Reset during the second half of a split store: only the first half lands.
      setup_directed();
      @(posedge clk);
      #1;
      bus.req       = 1'b1;
      bus.mem_write = 1'b1;
      bus.func3     = 3'b010;
      bus.addr      = 32'h5;
      bus.wdata     = 32'hA1B2_C3D4;
      @(negedge clk);
      chk("rsp_c1_ctl", ctl(), {27'h0, 5'b01010});
      chk("rsp_c1_be", 32'(bus.mem_be), 32'hE);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rsp_rst_ctl", ctl(), 32'h0);
      chk("rsp_rst_be", 32'(bus.mem_be), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk("rsp_after", ctl(), 32'h0);
      refb[5] = 8'hD4;
      refb[6] = 8'hC3;
      refb[7] = 8'hB2;
      chk("rsp_m1", mem[1], 32'hB2C3_D411);
      chk("rsp_m2", mem[2], 32'hDDCC_BBAA);
      run_op("rsp_lw8", 1'b1, 1'b0, 3'b010, 32'h8, 32'h0, ld);
      chk_mem("rsp_mem");

      // Randomised traffic over a randomly filled memory.
      for (int i = 0; i < int'(LIM); i++) refb[i] = 8'($urandom);
      preset_mem();
      for (int t = 0; t < 300; t++) begin
         r  = $urandom_range(0, 9);
         rd = (r <= 4);
         wr = (r == 0) || (r >= 5 && r <= 8);
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
         else if (wr) f3 = 3'($urandom_range(0, 2));
         else begin
            case ($urandom_range(0, 4))
               0: f3 = 3'b000;
               1: f3 = 3'b001;
               2: f3 = 3'b010;
               3: f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
         end
         case ($urandom_range(0, 9))
            0: a = $urandom;
            1: a = LIM - 8 + 32'($urandom_range(0, 15));
            default: a = 32'($urandom_range(0, LIM - 1));
         endcase
         run_op($sformatf("rnd%0d", t), rd, wr, f3, a, $urandom, ld);
      end
      chk_mem("rnd_mem");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
